// File: rtl/i2s_transmitter.sv
// I2S transmitter: divides CLK into BCLK/LRCLK and shifts 16-bit stereo
// pairs MSB-first with the one-BCLK I2S delay from a single-entry buffer.
module i2s_transmitter #(
    parameter int BCLK_DIV = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] leftSampleIn,
    input  logic [15:0] rightSampleIn,
    input  logic        sampleValid,
    output logic        sampleReady,
    output logic        frameStart,
    output logic        underrun,
    output logic        BCLK,
    output logic        LRCLK,
    output logic        SDATA
);

    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] divCnt_q, divCnt_d;
    logic          bclk_q, bclk_d;
    logic [4:0]    slot_q, slot_d;
    logic          lrclk_q, lrclk_d;
    logic [31:0]   shift_q, shift_d;
    logic [15:0]   holdL_q, holdL_d;
    logic [15:0]   holdR_q, holdR_d;
    logic          holdFull_q, holdFull_d;
    logic          frameStart_q, frameStart_d;
    logic          underrun_q, underrun_d;

    logic          divWrap;
    logic          fall;
    logic          load;
    logic [4:0]    slotNext;
    logic          capture;

    always_comb begin
        divCnt_d     = divCnt_q;
        bclk_d       = bclk_q;
        slot_d       = slot_q;
        lrclk_d      = lrclk_q;
        shift_d      = shift_q;
        holdL_d      = holdL_q;
        holdR_d      = holdR_q;
        holdFull_d   = holdFull_q;
        underrun_d   = underrun_q;

        divWrap      = (divCnt_q == DW'(BCLK_DIV - 1));
        fall         = divWrap && bclk_q;
        slotNext     = slot_q + 5'd1;
        load         = fall && (slotNext == 5'd1);
        capture      = sampleValid && !holdFull_q;
        frameStart_d = load;

        divCnt_d = divWrap ? '0 : divCnt_q + DW'(1);
        if (divWrap) begin
            bclk_d = ~bclk_q;
        end

        // Data and word select move together on the BCLK fall
        if (fall) begin
            slot_d  = slotNext;
            lrclk_d = slotNext[4];
            if (load) begin
                shift_d = {holdL_q, holdR_q};
            end else begin
                shift_d = {shift_q[30:0], 1'b0};
            end
        end

        if (capture) begin
            holdL_d    = leftSampleIn;
            holdR_d    = rightSampleIn;
            holdFull_d = 1'b1;
        end

        // Empty buffer at load: old pair goes out again, capture still allowed
        if (load) begin
            if (holdFull_q) begin
                holdFull_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            divCnt_q     <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= 5'd0;
            lrclk_q      <= 1'b0;
            shift_q      <= 32'd0;
            holdL_q      <= 16'd0;
            holdR_q      <= 16'd0;
            holdFull_q   <= 1'b0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            bclk_q       <= bclk_d;
            slot_q       <= slot_d;
            lrclk_q      <= lrclk_d;
            shift_q      <= shift_d;
            holdL_q      <= holdL_d;
            holdR_q      <= holdR_d;
            holdFull_q   <= holdFull_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sampleReady = ~holdFull_q;
    assign frameStart  = frameStart_q;
    assign underrun    = underrun_q;
    assign BCLK        = bclk_q;
    assign LRCLK       = lrclk_q;
    assign SDATA       = shift_q[31];

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: frame contents via a scoreboard
// queue, reset behaviour, underrun/overflow/collision cases and rates.
module tb_i2s_transmitter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] leftSampleIn = '0;
    logic [15:0] rightSampleIn = '0;
    logic        sampleValid = 1'b0;
    logic        sampleReady, frameStart, underrun, BCLK, LRCLK, SDATA;

    logic [15:0] l16 = '0;
    logic [15:0] r16 = '0;
    logic        v16 = 1'b0;
    logic        sampleReady16, frameStart16, underrun16;
    logic        BCLK16, LRCLK16, SDATA16;

    int          ntot = 0;
    int          npass = 0;
    int          cyc = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    i2s_transmitter #(.BCLK_DIV(2)) dut (
        .CLK(CLK), .RST(RST),
        .leftSampleIn(leftSampleIn), .rightSampleIn(rightSampleIn),
        .sampleValid(sampleValid), .sampleReady(sampleReady),
        .frameStart(frameStart), .underrun(underrun),
        .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA)
    );

    i2s_transmitter #(.BCLK_DIV(16)) dut16 (
        .CLK(CLK), .RST(RST),
        .leftSampleIn(l16), .rightSampleIn(r16),
        .sampleValid(v16), .sampleReady(sampleReady16),
        .frameStart(frameStart16), .underrun(underrun16),
        .BCLK(BCLK16), .LRCLK(LRCLK16), .SDATA(SDATA16)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        leftSampleIn  = l;
        rightSampleIn = r;
        sampleValid   = 1'b1;
        step();
        sampleValid   = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int g;
        g = 0;
        while (frameStart !== 1'b1 && g < 400) begin
            step();
            g++;
        end
        check(tag, {31'd0, frameStart}, 32'd1);
    endtask

    task automatic wait_rises(input int n);
        int k, g;
        logic pb;
        k = 0;
        g = 0;
        pb = BCLK;
        while (k < n && g < 400) begin
            step();
            g++;
            if (BCLK && !pb) k++;
            pb = BCLK;
        end
        check("rise_timeout", k, n);
    endtask

    // Called at the frameStart sample; collects slots 1..31 then slot 0
    task automatic capture_frame(input string tag);
        logic [31:0] d, lr, exp;
        int n, g;
        logic pb;
        d = '0;
        lr = '0;
        n = 0;
        g = 0;
        pb = BCLK;
        while (n < 32 && g < 400) begin
            step();
            g++;
            if (BCLK && !pb) begin
                d[31-n]  = SDATA;
                lr[31-n] = LRCLK;
                n++;
            end
            pb = BCLK;
        end
        check({tag, "_bits"}, n, 32);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_data"}, d, exp);
        check({tag, "_lrclk"}, lr, 32'h0001_FFFE);
    endtask

    initial begin
        int t0, tb, spacing, g;
        logic pb;

        // Reset values and start-up timing
        repeat (3) step();
        check("rst_bclk", {31'd0, BCLK}, 32'd0);
        check("rst_lrclk", {31'd0, LRCLK}, 32'd0);
        check("rst_sdata", {31'd0, SDATA}, 32'd0);
        check("rst_fs", {31'd0, frameStart}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_ready", {31'd0, sampleReady}, 32'd1);

        RST = 1'b0;
        sb.push_back({16'h8001, 16'h7FFE});
        send(16'h8001, 16'h7FFE);
        check("clk1_bclk", {31'd0, BCLK}, 32'd0);
        check("clk1_ready", {31'd0, sampleReady}, 32'd0);
        step();
        check("clk2_bclk", {31'd0, BCLK}, 32'd1);
        check("clk2_fs", {31'd0, frameStart}, 32'd0);
        step();
        step();
        check("clk4_fs", {31'd0, frameStart}, 32'd1);
        check("clk4_lrclk", {31'd0, LRCLK}, 32'd0);
        check("clk4_underrun", {31'd0, underrun}, 32'd0);
        capture_frame("bitorder");

        // No new sample: same 32 bits again, sticky underrun
        sb.push_back({16'h8001, 16'h7FFE});
        wait_fs("fs2");
        check("under_set", {31'd0, underrun}, 32'd1);
        capture_frame("underrun");
        check("under_sticky", {31'd0, underrun}, 32'd1);

        // Second strobe while full is dropped
        wait_fs("fs3");
        step();
        sb.push_back({16'h1111, 16'h3333});
        send(16'h1111, 16'h3333);
        check("ovf_ready", {31'd0, sampleReady}, 32'd0);
        step();
        send(16'h2222, 16'h4444);
        check("ovf_ready2", {31'd0, sampleReady}, 32'd0);
        wait_fs("fs4");
        check("load_ready", {31'd0, sampleReady}, 32'd1);
        capture_frame("overflow");

        // Mid-frame reset in slot 20
        wait_fs("fs5");
        wait_rises(20);
        check("slot20_lrclk", {31'd0, LRCLK}, 32'd1);
        RST = 1'b1;
        step();
        check("mid_bclk", {31'd0, BCLK}, 32'd0);
        check("mid_lrclk", {31'd0, LRCLK}, 32'd0);
        check("mid_sdata", {31'd0, SDATA}, 32'd0);
        check("mid_underrun", {31'd0, underrun}, 32'd0);
        check("mid_ready", {31'd0, sampleReady}, 32'd1);

        // Sample on the load edge with an empty buffer
        RST = 1'b0;
        sb.push_back({16'h1234, 16'h4321});
        send(16'h1234, 16'h4321);
        wait_fs("col_fs1");
        capture_frame("col_first");
        step();
        check("col_pre_under", {31'd0, underrun}, 32'd0);
        sb.push_back({16'h1234, 16'h4321});
        sb.push_back({16'hA5A5, 16'h5A5A});
        send(16'hA5A5, 16'h5A5A);
        check("col_fs", {31'd0, frameStart}, 32'd1);
        check("col_under", {31'd0, underrun}, 32'd1);
        check("col_ready", {31'd0, sampleReady}, 32'd0);
        capture_frame("col_repeat");
        wait_fs("col_fs3");
        capture_frame("col_new");

        // Rate at BCLK_DIV = 16
        g = 0;
        while (frameStart16 !== 1'b1 && g < 3000) begin
            step();
            g++;
        end
        check("rate_fs0", {31'd0, frameStart16}, 32'd1);
        t0 = cyc;
        tb = -1;
        pb = BCLK16;
        for (int f = 0; f < 10; f++) begin
            g = 0;
            step();
            while (frameStart16 !== 1'b1 && g < 3000) begin
                if (BCLK16 && !pb) begin
                    if (tb >= 0) check("bclk_period", cyc - tb, 32);
                    tb = cyc;
                end
                pb = BCLK16;
                step();
                g++;
            end
            pb = BCLK16;
            spacing = cyc - t0;
            check("fs_spacing", spacing, 1024);
            t0 = cyc;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises the processed stereo sample pair from the effects chain onto a standard I2S link toward the audio DAC. It generates BCLK and LRCLK from CLK and transmits 16-bit two's-complement left/right words MSB-first with the I2S one-BCLK delay. It buffers one sample pair in a single-entry holding register with a valid/ready handshake. It raises a sticky underrun flag when a frame starts with no fresh sample.

## Interface
- BCLK_DIV, 16, CLK cycles per BCLK half-period; legal range ≥ 2. With a 50 MHz CLK, the default gives BCLK = 1.5625 MHz and fs ≈ 48.83 kHz.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- leftSampleIn  in  16  signed left sample.
- rightSampleIn  in  16  signed right sample.
- sampleValid  in  1  one-CLK strobe; presents the pair on leftSampleIn/rightSampleIn.
- sampleReady  out  1  high when the holding register is empty.
- frameStart  out  1  one-CLK pulse when a pair is loaded into the shifter.
- underrun  out  1  sticky; set when a frame loads with the holding register empty.
- BCLK  out  1  bit clock to the DAC.
- LRCLK  out  1  word select: 0 = left, 1 = right.
- SDATA  out  1  serial data; changes on BCLK falling edge.

## Operation
- Divider:
  - divCnt counts 0..BCLK_DIV-1.
  - At divCnt == BCLK_DIV-1, divCnt wraps to 0 and BCLK toggles.
  - A 1→0 toggle is a "fall event".
- Slot counter:
  - slot runs 0..31 and advances by 1, mod 32, on each fall event.
  - One frame is 32 BCLK periods.
- LRCLK:
  - LRCLK is 0 for slots 0..15 and 1 for slots 16..31.
  - It is updated at the fall event that enters the slot.
- Shifter (32-bit register):
  - At the fall event entering slot 1 (the load event), the shifter loads {holdL, holdR} and SDATA is driven with holdL[15].
  - At every other fall event, the shifter shifts left by 1 and SDATA takes the new MSB.
  - Resulting slot map:
    - left MSB..LSB in slots 1..16;
    - right MSB in slot 17, and right bits continue through slot 31;
    - right LSB in slot 0 of the next frame.
- Holding register:
  - holdL and holdR are captured when sampleValid && sampleReady; holdFull is then set.
  - sampleReady = ~holdFull.
  - If sampleValid arrives while holdFull = 1, the new sample is dropped and the holding contents are unchanged.
- Load event with holdFull = 1:
  - The holding pair is transmitted and holdFull clears.
  - sampleReady rises on the next CLK.
- Load event with holdFull = 0:
  - holdL/holdR are unchanged, so the previous pair is retransmitted.
  - underrun is set and stays at 1 until RST.
- sampleValid on the same CLK as the load event:
  - The load uses the old contents.
  - sampleReady is still the pre-load value that cycle, so a valid with holdFull = 1 is dropped.
  - A valid with holdFull = 0 is captured for the next frame, and underrun is still set.
- frameStart is asserted on the CLK edge that performs the load event.
- Reset values:
  - All outputs: BCLK = 0, LRCLK = 0, SDATA = 0, frameStart = 0, underrun = 0, sampleReady = 1.
  - Internal state: divCnt = 0, slot = 0, shifter = 0, holdL = holdR = 0, holdFull = 0.
- RST asserted mid-frame aborts the frame; all state takes its reset value on that edge.

## Timing
- All outputs are registered.
- BCLK, LRCLK, SDATA and frameStart change only on CLK posedge.
- SDATA and LRCLK change on the same CLK edge as the BCLK fall. This gives the DAC BCLK_DIV CLK cycles of setup before BCLK rises.
- BCLK period is 2*BCLK_DIV CLK cycles; frame period is 64*BCLK_DIV CLK cycles.
- First BCLK rise occurs BCLK_DIV CLKs after RST deasserts.
- First fall event and first frameStart occur 2*BCLK_DIV CLKs after RST deasserts.
- Subsequent frameStarts are spaced exactly 64*BCLK_DIV CLKs apart.
- Capture latency: sampleValid to holdFull/sampleReady change is 1 CLK.
- Transmit latency: holding to SDATA MSB happens at the next load event, up to 64*BCLK_DIV CLKs later.
- The upstream effect issues sampleValid once per frameStart to avoid underrun.

## Test plan
- Reset:
  - Stimulus: hold RST for 3 CLK, release, BCLK_DIV = 2.
  - Required: outputs at reset values; BCLK rises at CLK 2 after release; first frameStart at CLK 4, with LRCLK = 0.
  - Stimulus: assert RST at slot 20.
  - Required: BCLK = LRCLK = SDATA = 0 on the next edge and underrun cleared.
- Bit order:
  - Stimulus: BCLK_DIV = 2; load L = 16'h8001, R = 16'h7FFE before the first frame.
  - Required, sampling SDATA on BCLK rise:
    - slots 1..16 give 1000_0000_0000_0001;
    - slots 17..31 then slot 0 give 0111_1111_1111_1110;
    - LRCLK is 1 exactly in slots 16..31.
- Underrun:
  - Stimulus: send one pair, then no more sampleValid.
  - Required: the second frame repeats the same 32 bits; underrun rises at the second frameStart and stays at 1.
- Overflow drop:
  - Stimulus: two sampleValid strobes 2 CLK apart, with L = 16'h1111 then L = 16'h2222.
  - Required: sampleReady = 0 after the first strobe; the next frame transmits 16'h1111.
- Load collision:
  - Stimulus: holdFull = 0 and sampleValid with L = 16'hA5A5 on the frameStart CLK.
  - Required: that frame repeats the old pair and underrun is set; the following frame transmits 16'hA5A5.
- Rate:
  - Stimulus: BCLK_DIV = 16 over 10 frames.
  - Required: BCLK period = 32 CLK; frameStart spacing = 1024 CLK; no jitter.
